// File: rtl/rtc_pkg.sv
// Shared constants and helpers for the rtc_core timekeeping block.
// Field limits, widths, wrap-around adders and the 24 h -> 12 h display mapping.
package rtc_pkg;

   localparam int HOUR_W = 5;
   localparam int MS_W   = 6;

   localparam logic [MS_W-1:0]   SEC_MAX  = 6'd59;
   localparam logic [MS_W-1:0]   MIN_MAX  = 6'd59;
   localparam logic [HOUR_W-1:0] HOUR_MAX = 5'd23;

   // Adds 0..2 to a minute/second value and wraps past max_v back towards 0.
   function automatic logic [MS_W-1:0] wrap_ms(input logic [MS_W-1:0] val,
                                                input logic [1:0]      inc,
                                                input logic [MS_W-1:0] max_v);
      logic [MS_W:0] sum;
      sum = {1'b0, val} + {{(MS_W-1){1'b0}}, inc};
      if (sum > {1'b0, max_v}) begin
         sum = sum - ({1'b0, max_v} + 7'd1);
      end
      return sum[MS_W-1:0];
   endfunction

   function automatic logic [HOUR_W-1:0] wrap_hour(input logic [HOUR_W-1:0] val,
                                                   input logic [1:0]        inc);
      logic [HOUR_W:0] sum;
      sum = {1'b0, val} + {{(HOUR_W-1){1'b0}}, inc};
      if (sum > {1'b0, HOUR_MAX}) begin
         sum = sum - 6'd24;
      end
      return sum[HOUR_W-1:0];
   endfunction

   // Returns {pm, hour12}: 0 -> 12 AM, 12 -> 12 PM, 13..23 -> 1..11 PM.
   function automatic logic [HOUR_W:0] to_12h(input logic [HOUR_W-1:0] hour);
      logic              pm;
      logic [HOUR_W-1:0] h12;
      pm = (hour >= 5'd12);
      if (hour == 5'd0) begin
         h12 = 5'd12;
      end else if (hour > 5'd12) begin
         h12 = hour - 5'd12;
      end else begin
         h12 = hour;
      end
      return {pm, h12};
   endfunction

endpackage

// File: rtl/rtc_core_btn.sv
// Held-button auto-repeat: one pulse on press, another HOLD_DLY cycles later,
// then one every REPEAT cycles until release.
module btn_repeat #(
   parameter int HOLD_DLY = 5,
   parameter int REPEAT   = 2
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic lvl_i,
   output logic pulse_o
);

   localparam int MAXC = (HOLD_DLY > REPEAT) ? HOLD_DLY : REPEAT;
   localparam int CW   = $clog2(MAXC + 1);
   localparam logic [CW-1:0] HOLD_C = CW'(HOLD_DLY);
   localparam logic [CW-1:0] REP_C  = CW'(REPEAT);
   localparam logic [CW-1:0] ONE    = CW'(1);

   logic          lvl_q;
   logic          rep_q, rep_d;
   logic [CW-1:0] cnt_q, cnt_d;

   // cnt_q counts cycles since the last pulse; rep_q marks the repeat phase.
   always_comb begin
      pulse_o = 1'b0;
      cnt_d   = cnt_q;
      rep_d   = rep_q;
      if (!lvl_i) begin
         cnt_d = '0;
         rep_d = 1'b0;
      end else if (!lvl_q) begin
         pulse_o = 1'b1;
         cnt_d   = ONE;
         rep_d   = 1'b0;
      end else if ((!rep_q && cnt_q == HOLD_C) || (rep_q && cnt_q == REP_C)) begin
         pulse_o = 1'b1;
         cnt_d   = ONE;
         rep_d   = 1'b1;
      end else begin
         cnt_d = cnt_q + ONE;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         lvl_q <= 1'b0;
         cnt_q <= '0;
         rep_q <= 1'b0;
      end else begin
         lvl_q <= lvl_i;
         cnt_q <= cnt_d;
         rep_q <= rep_d;
      end
   end

endmodule

// File: rtl/rtc_core.sv
// Timekeeping core: prescaler, h:m:s counter, alarm compare and 12/24 h output.
// Internal state is always 24 h; all outputs are registered from next state.
module rtc_core
   import rtc_pkg::*;
#(
   parameter int TPS       = 10,
   parameter int FAST_TPS  = 2,
   parameter int HOLD_DLY  = 5,
   parameter int REPEAT    = 2,
   parameter int ALARM_LEN = 60
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              run_i,
   input  logic              fast_i,
   input  logic              inc_hour_i,
   input  logic              inc_min_i,
   input  logic              sel_alarm_i,
   input  logic              alarm_en_i,
   input  logic              fmt12_i,
   output logic [HOUR_W-1:0] hour_o,
   output logic [MS_W-1:0]   min_o,
   output logic [MS_W-1:0]   sec_o,
   output logic              pm_o,
   output logic              sec_pulse_o,
   output logic              alarm_o
);

   localparam int PW  = $clog2(TPS);
   localparam int ALW = $clog2(ALARM_LEN + 1);
   localparam logic [PW-1:0]  LIM_SLOW  = PW'(TPS - 1);
   localparam logic [PW-1:0]  LIM_FAST  = PW'(FAST_TPS - 1);
   localparam logic [ALW-1:0] ALEN_LAST = ALW'(ALARM_LEN - 1);

   logic              pulse_h, pulse_m;
   logic              hlvl_q, mlvl_q;
   logic              rise_h, rise_m;
   logic              edit_h, edit_m, dismiss;
   logic              tick, sec_carry, min_carry, trigger;

   logic [PW-1:0]     pre_q, pre_d;
   logic [MS_W-1:0]   sec_q, sec_d, min_q, min_d, amin_q, amin_d;
   logic [HOUR_W-1:0] hour_q, hour_d, ahour_q, ahour_d;
   logic              alarm_q, alarm_d;
   logic [ALW-1:0]    acnt_q, acnt_d;

   logic [HOUR_W-1:0] disp_h, h12, hour_out_q, hour_out_d;
   logic [MS_W-1:0]   disp_m, min_out_q, sec_out_q, sec_out_d;
   logic              pm12, pm_q, pm_d, spulse_q;

   btn_repeat #(.HOLD_DLY(HOLD_DLY), .REPEAT(REPEAT)) u_btn_hour (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .lvl_i   (inc_hour_i),
      .pulse_o (pulse_h)
   );

   btn_repeat #(.HOLD_DLY(HOLD_DLY), .REPEAT(REPEAT)) u_btn_min (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .lvl_i   (inc_min_i),
      .pulse_o (pulse_m)
   );

   // A press while the alarm sounds only silences it; held repeats still edit.
   assign rise_h  = inc_hour_i & ~hlvl_q;
   assign rise_m  = inc_min_i & ~mlvl_q;
   assign dismiss = alarm_q & (rise_h | rise_m);
   assign edit_h  = pulse_h & ~(alarm_q & rise_h);
   assign edit_m  = pulse_m & ~(alarm_q & rise_m);

   always_comb begin
      pre_d = pre_q;
      tick  = 1'b0;
      if (run_i) begin
         if (pre_q >= (fast_i ? LIM_FAST : LIM_SLOW)) begin
            pre_d = '0;
            tick  = 1'b1;
         end else begin
            pre_d = pre_q + PW'(1);
         end
      end
   end

   // Carries come from the tick alone, so an edit never ripples upward.
   always_comb begin
      sec_carry = tick & (sec_q == SEC_MAX);
      min_carry = sec_carry & (min_q == MIN_MAX);
      sec_d     = tick ? wrap_ms(sec_q, 2'd1, SEC_MAX) : sec_q;
      min_d     = wrap_ms(min_q, {1'b0, sec_carry} + {1'b0, edit_m & ~sel_alarm_i}, MIN_MAX);
      hour_d    = wrap_hour(hour_q, {1'b0, min_carry} + {1'b0, edit_h & ~sel_alarm_i});
      amin_d    = wrap_ms(amin_q, {1'b0, edit_m & sel_alarm_i}, MIN_MAX);
      ahour_d   = wrap_hour(ahour_q, {1'b0, edit_h & sel_alarm_i});
   end

   always_comb begin
      alarm_d = alarm_q;
      acnt_d  = acnt_q;
      trigger = tick & alarm_en_i & (sec_d == '0) & (min_d == amin_q) & (hour_d == ahour_q);
      if (!alarm_en_i) begin
         alarm_d = 1'b0;
         acnt_d  = '0;
      end else if (trigger) begin
         alarm_d = 1'b1;
         acnt_d  = '0;
      end else if (dismiss) begin
         alarm_d = 1'b0;
         acnt_d  = '0;
      end else if (alarm_q && tick) begin
         if (acnt_q == ALEN_LAST) begin
            alarm_d = 1'b0;
            acnt_d  = '0;
         end else begin
            acnt_d = acnt_q + ALW'(1);
         end
      end
   end

   always_comb begin
      disp_h        = sel_alarm_i ? ahour_d : hour_d;
      disp_m        = sel_alarm_i ? amin_d : min_d;
      {pm12, h12}   = to_12h(disp_h);
      hour_out_d    = fmt12_i ? h12 : disp_h;
      pm_d          = fmt12_i & pm12;
      sec_out_d     = sel_alarm_i ? '0 : sec_d;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         pre_q      <= '0;
         sec_q      <= '0;
         min_q      <= '0;
         hour_q     <= '0;
         amin_q     <= '0;
         ahour_q    <= '0;
         alarm_q    <= 1'b0;
         acnt_q     <= '0;
         hlvl_q     <= 1'b0;
         mlvl_q     <= 1'b0;
         hour_out_q <= fmt12_i ? 5'd12 : 5'd0;
         min_out_q  <= '0;
         sec_out_q  <= '0;
         pm_q       <= 1'b0;
         spulse_q   <= 1'b0;
      end else begin
         pre_q      <= pre_d;
         sec_q      <= sec_d;
         min_q      <= min_d;
         hour_q     <= hour_d;
         amin_q     <= amin_d;
         ahour_q    <= ahour_d;
         alarm_q    <= alarm_d;
         acnt_q     <= acnt_d;
         hlvl_q     <= inc_hour_i;
         mlvl_q     <= inc_min_i;
         hour_out_q <= hour_out_d;
         min_out_q  <= disp_m;
         sec_out_q  <= sec_out_d;
         pm_q       <= pm_d;
         spulse_q   <= tick;
      end
   end

   assign hour_o      = hour_out_q;
   assign min_o       = min_out_q;
   assign sec_o       = sec_out_q;
   assign pm_o        = pm_q;
   assign sec_pulse_o = spulse_q;
   assign alarm_o     = alarm_q;

endmodule

// File: tb/tb_rtc_core.sv
// Directed-vector bench for rtc_core with hand-computed expectations.
module tb_rtc_core;

   logic       clk_i = 1'b0;
   logic       rst_i, run_i, fast_i, inc_hour_i, inc_min_i;
   logic       sel_alarm_i, alarm_en_i, fmt12_i;
   logic [4:0] hour_o;
   logic [5:0] min_o, sec_o;
   logic       pm_o, sec_pulse_o, alarm_o;

   int n_vec = 0;
   int n_bad = 0;

   rtc_core #(.TPS(10), .FAST_TPS(2), .HOLD_DLY(5), .REPEAT(2), .ALARM_LEN(3)) dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .run_i       (run_i),
      .fast_i      (fast_i),
      .inc_hour_i  (inc_hour_i),
      .inc_min_i   (inc_min_i),
      .sel_alarm_i (sel_alarm_i),
      .alarm_en_i  (alarm_en_i),
      .fmt12_i     (fmt12_i),
      .hour_o      (hour_o),
      .min_o       (min_o),
      .sec_o       (sec_o),
      .pm_o        (pm_o),
      .sec_pulse_o (sec_pulse_o),
      .alarm_o     (alarm_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic check_time(input string tag, input int h, input int m, input int s);
      check_eq({tag, ".hour"}, 32'(hour_o), 32'(h));
      check_eq({tag, ".min"}, 32'(min_o), 32'(m));
      check_eq({tag, ".sec"}, 32'(sec_o), 32'(s));
   endtask

   task automatic press_h(input int n);
      for (int i = 0; i < n; i++) begin
         inc_hour_i = 1'b1;
         step();
         inc_hour_i = 1'b0;
         step();
      end
   endtask

   task automatic press_m(input int n);
      for (int i = 0; i < n; i++) begin
         inc_min_i = 1'b1;
         step();
         inc_min_i = 1'b0;
         step();
      end
   endtask

   task automatic do_reset();
      rst_i = 1'b1;
      run_i = 1'b0; fast_i = 1'b0; inc_hour_i = 1'b0; inc_min_i = 1'b0;
      sel_alarm_i = 1'b0; alarm_en_i = 1'b0; fmt12_i = 1'b0;
      step();
      rst_i = 1'b0;
   endtask

   // Runs until n second strobes have been seen, then freezes the clock.
   task automatic run_ticks(input int n);
      int seen = 0;
      int cyc  = 0;
      run_i = 1'b1;
      while (seen < n && cyc < 10 * n + 4) begin
         step();
         cyc++;
         if (sec_pulse_o) seen++;
      end
      run_i = 1'b0;
      check_eq("tick_count", 32'(seen), 32'(n));
   endtask

   task automatic preload(input int h, input int m, input int s);
      do_reset();
      press_h(h);
      press_m(m);
      fast_i = 1'b1;
      if (s > 0) run_ticks(s);
   endtask

   task automatic set_alarm_0001();
      do_reset();
      sel_alarm_i = 1'b1;
      press_m(1);
      sel_alarm_i = 1'b0;
      alarm_en_i  = 1'b1;
      fast_i      = 1'b1;
   endtask

   initial begin
      int pcnt;
      int pidx [3];
      int seen;

      // Reset state, 24 h and 12 h
      do_reset();
      step();
      check_time("rst", 0, 0, 0);
      check_eq("rst.pm", 32'(pm_o), 0);
      check_eq("rst.spulse", 32'(sec_pulse_o), 0);
      check_eq("rst.alarm", 32'(alarm_o), 0);
      rst_i = 1'b1; fmt12_i = 1'b1;
      step();
      check_eq("rst12.hour", 32'(hour_o), 12);
      check_eq("rst12.pm", 32'(pm_o), 0);
      fmt12_i = 1'b0;
      rst_i = 1'b0;

      // Normal prescale: 30 cycles -> 3 strobes at cycles 10, 20, 30
      pcnt = 0;
      run_i = 1'b1;
      for (int i = 1; i <= 30; i++) begin
         step();
         if (sec_pulse_o) begin
            if (pcnt < 3) pidx[pcnt] = i;
            pcnt++;
         end
      end
      run_i = 1'b0;
      check_eq("prescale.pulses", 32'(pcnt), 3);
      check_eq("prescale.p0", 32'(pidx[0]), 10);
      check_eq("prescale.p1", 32'(pidx[1]), 20);
      check_eq("prescale.p2", 32'(pidx[2]), 30);
      check_eq("prescale.sec", 32'(sec_o), 3);
      step();
      check_eq("frozen.spulse", 32'(sec_pulse_o), 0);
      check_eq("frozen.sec", 32'(sec_o), 3);

      // Preload 23:59:59 from 00:00:03, then a tick rolls over everything
      press_h(23);
      press_m(59);
      fast_i = 1'b1;
      run_ticks(56);
      check_time("pre2359", 23, 59, 59);
      run_ticks(1);
      check_time("rollover", 0, 0, 0);
      fmt12_i = 1'b1;
      step();
      check_eq("12h.midnight.hour", 32'(hour_o), 12);
      check_eq("12h.midnight.pm", 32'(pm_o), 0);
      press_h(13);
      check_eq("12h.13.hour", 32'(hour_o), 1);
      check_eq("12h.13.pm", 32'(pm_o), 1);
      fmt12_i = 1'b0;
      step();
      check_eq("24h.13.hour", 32'(hour_o), 13);
      check_eq("24h.13.pm", 32'(pm_o), 0);

      // Auto-repeat: 10-cycle hold pulses at hold cycles 0, 5, 7, 9
      inc_min_i = 1'b1;
      for (int i = 0; i < 6; i++) step();
      check_eq("hold6.min", 32'(min_o), 2);
      for (int i = 0; i < 4; i++) step();
      inc_min_i = 1'b0;
      step();
      check_eq("hold10.min", 32'(min_o), 4);
      press_m(1);
      check_eq("repress.min", 32'(min_o), 5);
      check_eq("repress.hour", 32'(hour_o), 13);

      // Minute edit wraps without carry
      preload(7, 59, 0);
      press_m(1);
      check_time("minwrap", 7, 0, 0);

      // Tick and minute press in the same cycle at 10:59:59
      preload(10, 59, 59);
      run_i = 1'b1;
      step();
      inc_min_i = 1'b1;
      step();
      check_time("tick+min", 11, 1, 0);
      run_i = 1'b0; inc_min_i = 1'b0;
      step();

      // Tick and hour press in the same cycle at 23:59:59
      preload(23, 59, 59);
      run_i = 1'b1;
      step();
      inc_hour_i = 1'b1;
      step();
      check_time("tick+hour", 1, 0, 0);
      run_i = 1'b0; inc_hour_i = 1'b0;
      step();

      // Alarm at 00:01, dismissed by a button press that does not edit
      set_alarm_0001();
      sel_alarm_i = 1'b1;
      step();
      check_time("alarmview", 0, 1, 0);
      sel_alarm_i = 1'b0;
      step();
      check_eq("timeview.min", 32'(min_o), 0);
      seen = 0;
      run_i = 1'b1;
      for (int i = 0; i < 200; i++) begin
         step();
         if (sec_pulse_o) seen++;
         if (alarm_o) break;
      end
      run_i = 1'b0;
      check_eq("alarm.rise_tick", 32'(seen), 60);
      check_eq("alarm.rise", 32'(alarm_o), 1);
      check_time("alarm.at", 0, 1, 0);
      press_h(1);
      check_eq("dismiss.alarm", 32'(alarm_o), 0);
      check_eq("dismiss.hour", 32'(hour_o), 0);

      // Alarm lapses after ALARM_LEN = 3 further ticks
      set_alarm_0001();
      run_ticks(60);
      check_eq("len.t60", 32'(alarm_o), 1);
      run_ticks(2);
      check_eq("len.t62", 32'(alarm_o), 1);
      run_ticks(1);
      check_eq("len.t63", 32'(alarm_o), 0);

      // Disarming clears an active alarm
      set_alarm_0001();
      run_ticks(60);
      check_eq("disarm.pre", 32'(alarm_o), 1);
      alarm_en_i = 1'b0;
      step();
      check_eq("disarm.alarm", 32'(alarm_o), 0);

      // Reset during an active alarm and in the middle of a hold
      set_alarm_0001();
      run_ticks(60);
      check_eq("rstalarm.pre", 32'(alarm_o), 1);
      rst_i = 1'b1;
      step();
      check_eq("rstalarm.alarm", 32'(alarm_o), 0);
      check_time("rstalarm", 0, 0, 0);
      rst_i = 1'b0;
      sel_alarm_i = 1'b1;
      step();
      check_eq("rstalarm.amin", 32'(min_o), 0);
      sel_alarm_i = 1'b0;
      inc_min_i = 1'b1;
      for (int i = 0; i < 3; i++) step();
      check_eq("midhold.min", 32'(min_o), 1);
      rst_i = 1'b1;
      step();
      check_eq("midhold.rst", 32'(min_o), 0);
      inc_min_i = 1'b0;
      step();
      rst_i = 1'b0;
      for (int i = 0; i < 8; i++) step();
      check_time("after_release", 0, 0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
